// File: rtl/vend_change_if.sv
// Coin-acceptor to vend-controller bus: coin/cancel strobes in, dispense/change/reject pulses and credit out.
interface vend_change_if #(
    parameter int CREDIT_W = 4
);
    logic [1:0]          coin;
    logic                cancel;
    logic                newspaper;
    logic                change_nickel;
    logic                coin_reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output coin, cancel,
        input  newspaper, change_nickel, coin_reject, busy, credit
    );

    modport slave (
        input  coin, cancel,
        output newspaper, change_nickel, coin_reject, busy, credit
    );
endinterface

// File: rtl/vend_change.sv
// Parametrised vending controller: collects nickel/dime/quarter credit, dispenses one item at PRICE,
// then pays back any surplus one nickel per cycle. Cancel refunds the whole credit the same way.
module vend_change #(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4,
    parameter int Q_UNITS  = 5
) (
    input  logic         clock,
    input  logic         reset,
    vend_change_if.slave bus
);
    localparam int SW = CREDIT_W + 3;
    localparam logic [SW-1:0]       MAX_C   = SW'((1 << CREDIT_W) - 1);
    localparam logic [SW-1:0]       PRICE_W = SW'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [SW-1:0]       Q_VAL   = SW'(Q_UNITS);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    state_t              state_q, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic                reject_q, reject_nxt;
    logic [SW-1:0]       coin_val;
    logic [SW-1:0]       sum;
    logic [CREDIT_W-1:0] after_sale;

    always_comb begin
        case (bus.coin)
            2'b01:   coin_val = SW'(1);
            2'b10:   coin_val = SW'(2);
            2'b11:   coin_val = Q_VAL;
            default: coin_val = '0;
        endcase
    end

    // Sum is kept wide so an overflowing coin is detected rather than wrapped.
    assign sum        = {3'b000, credit_q} + coin_val;
    assign after_sale = credit_q - PRICE_C;

    always_comb begin
        state_nxt  = state_q;
        credit_nxt = credit_q;
        reject_nxt = 1'b0;
        case (state_q)
            COLLECT: begin
                if (bus.cancel) begin
                    reject_nxt = (bus.coin != 2'b00);
                    if (credit_q != '0) state_nxt = CHANGE;
                end else if (bus.coin != 2'b00) begin
                    if (sum > MAX_C) begin
                        reject_nxt = 1'b1;
                    end else begin
                        credit_nxt = sum[CREDIT_W-1:0];
                        if (sum >= PRICE_W) state_nxt = VEND;
                    end
                end
            end
            VEND: begin
                reject_nxt = (bus.coin != 2'b00);
                credit_nxt = after_sale;
                state_nxt  = (after_sale != '0) ? CHANGE : COLLECT;
            end
            CHANGE: begin
                reject_nxt = (bus.coin != 2'b00);
                if (credit_q <= CREDIT_W'(1)) begin
                    credit_nxt = '0;
                    state_nxt  = COLLECT;
                end else begin
                    credit_nxt = credit_q - CREDIT_W'(1);
                end
            end
            default: begin
                credit_nxt = '0;
                state_nxt  = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= COLLECT;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            credit_q <= credit_nxt;
            reject_q <= reject_nxt;
        end
    end

    assign bus.newspaper     = (state_q == VEND);
    assign bus.change_nickel = (state_q == CHANGE);
    assign bus.busy          = (state_q != COLLECT);
    assign bus.coin_reject   = reject_q;
    assign bus.credit        = credit_q;
endmodule
